pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 16 +
 rtl/pc_handoff_chk.sv | 12 +
 rtl/pc_sequencer.sv | 77 +++++++
 tb/tb_pc_sequencer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the PC sequencer: state encoding and address width.
package pc_sequencer_pkg;
  localparam int ADDR_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } seq_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/pc_handoff_chk.sv
// Combinational sanity checks on the next-PC returned by the core.
import pc_sequencer_pkg::*;

module pc_handoff_chk (
  input  logic [ADDR_W-1:0] addr_o,
  input  logic [ADDR_W-1:0] addr_in,
  output logic              misaligned,
  output logic              self_loop
);
  assign misaligned = |addr_o[1:0];
  assign self_loop  = (addr_o == addr_in);
endmodule

// File: rtl/pc_sequencer.sv
// Drives the core PC from its returned next-PC, one registered handoff per
// enabled edge, with single-step, self-loop halt, misalignment trap and run limit.
import pc_sequencer_pkg::*;

module pc_sequencer #(
  parameter logic [ADDR_W-1:0] RESET_ADDR = 32'h0000_0000,
  parameter int                MAX_CYCLES = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              step_en,
  input  logic              step,
  input  logic [ADDR_W-1:0] addr_o,
  output logic [ADDR_W-1:0] addr_in,
  output logic [CNT_W-1:0]  cycle_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CYCLES);

  seq_state_e       state, state_nx;
  logic             misaligned, self_loop, handoff;
  logic [CNT_W-1:0] cnt_inc;

  pc_handoff_chk u_chk (
    .addr_o    (addr_o),
    .addr_in   (addr_in),
    .misaligned(misaligned),
    .self_loop (self_loop)
  );

  assign handoff = (state == RUN) && (!step_en || step);
  assign cnt_inc = sat_inc(cycle_cnt);

  // Priority on a handoff: misalignment, self-loop, then run limit.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DONE: if (start) state_nx = RUN;
      RUN: if (handoff) begin
        if (misaligned)            state_nx = ERROR;
        else if (self_loop)        state_nx = DONE;
        else if (cnt_inc == MAX_C) state_nx = DONE;
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr_in   <= RESET_ADDR;
      cycle_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == RUN);
      done  <= (state_nx == DONE);
      err   <= (state_nx == ERROR);
      case (state)
        IDLE, DONE: if (start) begin
          addr_in   <= RESET_ADDR;
          cycle_cnt <= '0;
        end
        RUN: if (handoff && !misaligned) begin
          cycle_cnt <= cnt_inc;
          if (!self_loop) addr_in <= addr_o;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: a behavioural model pushes expected post-edge outputs per
// cycle, which are popped and compared after each rising edge.
module tb_pc_sequencer;
  localparam logic [31:0] RA = 32'h0000_0000;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2, S_ERR = 3;

  typedef struct {
    int          st;
    logic [31:0] a;
    logic [15:0] c;
  } exp_t;

  logic        clk = 0, rst_n = 0, start = 0, step_en = 0, step = 0;
  logic [31:0] addr_o, addr_in;
  logic [15:0] cycle_cnt;
  logic        busy, done, err;

  int          n_cmp = 0, n_bad = 0;
  int          mode = 0;
  exp_t        q[$];
  int          m_st = S_IDLE;
  logic [31:0] m_addr = RA;
  logic [15:0] m_cnt = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_en(step_en), .step(step),
    .addr_o(addr_o), .addr_in(addr_in), .cycle_cnt(cycle_cnt),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Core model: 0 = sequential, 1 = spins at 0x10, 2 = returns 6 from 0x8.
  always_comb begin
    addr_o = addr_in + 32'd4;
    if (mode == 1 && addr_in == 32'h10) addr_o = 32'h10;
    if (mode == 2 && addr_in == 32'h8)  addr_o = 32'h6;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags(input int st);
    case (st)
      S_RUN:   return 32'b100;
      S_DONE:  return 32'b010;
      S_ERR:   return 32'b001;
      default: return 32'b000;
    endcase
  endfunction

  // One clock: drive inputs, advance model, push expectation, compare after edge.
  task automatic tick(input logic st, input logic sp);
    exp_t e, g;
    start = st;
    step  = sp;
    #1;
    if (!rst_n) begin
      m_st = S_IDLE; m_addr = RA; m_cnt = 0;
    end else if ((m_st == S_IDLE || m_st == S_DONE) && start) begin
      m_st = S_RUN; m_addr = RA; m_cnt = 0;
    end else if (m_st == S_RUN && (!step_en || step)) begin
      if (addr_o[1:0] != 2'b00) m_st = S_ERR;
      else begin
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 1;
        if (addr_o == m_addr) m_st = S_DONE;
        else begin
          m_addr = addr_o;
          if (m_cnt == 16'd23) m_st = S_DONE;
        end
      end
    end
    e.st = m_st; e.a = m_addr; e.c = m_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    start = 0;
    step  = 0;
    if (q.size() == 0) chk("queue_empty", 32'd0, 32'd1);
    else begin
      g = q.pop_front();
      chk("addr_in", addr_in, g.a);
      chk("cycle_cnt", 32'(cycle_cnt), 32'(g.c));
      chk("flags", {29'd0, busy, done, err}, flags(g.st));
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick(0, 0);
    tick(0, 0);
    rst_n = 1;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_addr", addr_in, 32'h0);
    chk("rst_flags", {29'd0, busy, done, err}, 32'b000);
    tick(0, 0);

    // Free run with a stray start mid-run, to completion
    mode = 0;
    tick(1, 0);
    chk("start_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 26; i++) tick(i == 5, 0);
    chk("free_done", 32'(done), 32'd1);
    chk("free_addr", addr_in, 32'h5C);
    chk("free_cnt", 32'(cycle_cnt), 32'd23);
    tick(0, 0);

    // Restart from DONE, then reset at cycle_cnt == 7
    tick(1, 0);
    chk("restart_addr", addr_in, RA);
    chk("restart_cnt", 32'(cycle_cnt), 32'd0);
    for (int i = 0; i < 7; i++) tick(0, 0);
    chk("pre_rst_cnt", 32'(cycle_cnt), 32'd7);
    rst_n = 0;
    tick(0, 0);
    rst_n = 1;
    chk("midrst_addr", addr_in, 32'h0);
    chk("midrst_cnt", 32'(cycle_cnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    // Self-loop halt
    mode = 1;
    tick(1, 0);
    for (int i = 0; i < 8; i++) tick(0, 0);
    chk("loop_done", 32'(done), 32'd1);
    chk("loop_addr", addr_in, 32'h10);
    chk("loop_cnt", 32'(cycle_cnt), 32'd5);

    // Misalignment trap; start ignored in ERROR
    do_reset();
    mode = 2;
    tick(1, 0);
    for (int i = 0; i < 5; i++) tick(0, 0);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_addr", addr_in, 32'h8);
    chk("mis_cnt", 32'(cycle_cnt), 32'd2);
    tick(1, 0);
    tick(0, 0);
    chk("mis_stuck", {29'd0, busy, done, err}, 32'b001);

    // Single-step: three pulses spaced 4 cycles apart
    do_reset();
    mode = 0;
    step_en = 1;
    tick(1, 0);
    for (int s = 0; s < 3; s++) begin
      tick(0, 1);
      for (int h = 0; h < 3; h++) tick(0, 0);
    end
    chk("step_addr", addr_in, 32'hC);
    chk("step_cnt", 32'(cycle_cnt), 32'd3);
    step_en = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
